// File: rtl/rr_arbiter_32_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_32_if;
   logic [31:0] req;
   logic        done;
   logic [31:0] gnt;
   logic [4:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   modport master (
      output req, done,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_idx, gnt_valid, timeout
   );
endinterface

// File: rtl/rr_arbiter_32.sv
// 32-way round-robin arbiter, grant held until release, one-hot and index outputs.
// Optional forced revoke after TIMEOUT cycles when ARB_TIMEOUT_EN is defined.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  S_IDLE  | no owner; pick first req at or after r_ptr on next edge
//  S_GRANT | owner r_gnt_idx holds the resource until release/revoke
module rr_arbiter_32 #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   rr_arbiter_32_if.slave bus
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t      r_state;
   logic [4:0]  r_ptr;
   logic [31:0] r_gnt;
   logic [4:0]  r_gnt_idx;
   logic        r_gnt_valid;
   logic        r_timeout;

   logic [31:0] w_rot;
   logic [4:0]  w_off;
   logic [4:0]  w_pick;
   logic        w_any;
   logic        w_release;
   logic        w_expire;

   // Rotate so r_ptr lands at bit 0; the lowest set bit is then the winner.
   always_comb begin
      w_rot  = 32'({bus.req, bus.req} >> r_ptr);
      w_off  = '0;
      for (int i = 31; i >= 0; i--) begin
         if (w_rot[i]) w_off = 5'(i);
      end
      w_pick = r_ptr + w_off;
   end

   assign w_any     = |bus.req;
   assign w_release = bus.done | ~bus.req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
   localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

   logic [4:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 5'd1;
      end
   end

   assign w_expire = (r_cnt == TO_LAST);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^5'(TIMEOUT - 1);
   assign w_expire         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_timeout <= 1'b0;
               if (w_any) begin
                  r_state     <= S_GRANT;
                  r_gnt       <= 32'b1 << w_pick;
                  r_gnt_idx   <= w_pick;
                  r_gnt_valid <= 1'b1;
               end
            end
            S_GRANT: begin
               if (w_release || w_expire) begin
                  r_state     <= S_IDLE;
                  r_ptr       <= r_gnt_idx + 5'd1;
                  r_gnt       <= '0;
                  r_gnt_idx   <= '0;
                  r_gnt_valid <= 1'b0;
                  // A genuine release on the expiry cycle is not a timeout.
                  r_timeout   <= w_expire & ~w_release;
               end else begin
                  r_timeout   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_idx   = r_gnt_idx;
   assign bus.gnt_valid = r_gnt_valid;
   assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Bench for rr_arbiter_32: directed vector table, timeout sequence, random run vs model.
module tb_rr_arbiter_32;

   localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk;
   logic reset;

   rr_arbiter_32_if bus ();

   rr_arbiter_32 #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: owner (-1 = none), rotation start, cycles held.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_to    = 1'b0;

   function automatic void model_step(input bit rst, input logic [31:0] rq, input bit dn);
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 0; k < 32; k++) begin
            if (rq[(m_ptr + k) % 32]) begin
               m_owner = (m_ptr + k) % 32;
               m_hold  = 0;
               break;
            end
         end
      end else begin
         bit rel, exp_to;
         rel    = dn || !rq[m_owner];
         exp_to = TO_EN && (m_hold == TIMEOUT - 1);
         if (rel || exp_to) begin
            m_ptr   = (m_owner + 1) % 32;
            m_to    = !rel;
            m_owner = -1;
         end else begin
            m_to   = 1'b0;
            m_hold = m_hold + 1;
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Drive inputs, take one rising edge, then leave the bench at the falling edge.
   task automatic cycle(input bit rst, input logic [31:0] rq, input bit dn);
      reset    = rst;
      bus.req  = rq;
      bus.done = dn;
      @(posedge clk);
      model_step(rst, rq, dn);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e_gnt;
      e_gnt = (m_owner >= 0) ? (32'b1 << m_owner) : 32'b0;
      check({tag, ".gnt"},       bus.gnt,                 e_gnt);
      check({tag, ".gnt_idx"},   32'(bus.gnt_idx),        (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check({tag, ".gnt_valid"}, 32'(bus.gnt_valid),      32'(m_owner >= 0));
      check({tag, ".timeout"},   32'(bus.timeout),        32'(m_to));
   endtask

   typedef struct {
      bit          rst;
      logic [31:0] req;
      bit          done;
      logic [31:0] e_gnt;
      logic [4:0]  e_idx;
      bit          e_vld;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit r, input logic [31:0] q, input bit d,
                               input logic [31:0] g, input logic [4:0] x, input bit v);
      vec_t t;
      t.rst = r; t.req = q; t.done = d; t.e_gnt = g; t.e_idx = x; t.e_vld = v;
      vecs.push_back(t);
   endfunction

   initial begin
      reset    = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;
      @(negedge clk);

      // reset held with all requests
      add(1, 32'hFFFF_FFFF, 0, 32'h0, 5'd0, 0);
      add(1, 32'hFFFF_FFFF, 0, 32'h0, 5'd0, 0);
      // single request, release, regrant after dead cycle
      add(0, 32'h0200_0000, 0, 32'h0200_0000, 5'd25, 1);
      add(0, 32'h0200_0000, 0, 32'h0200_0000, 5'd25, 1);
      add(0, 32'h0200_0000, 1, 32'h0,         5'd0,  0);
      add(0, 32'h0200_0000, 0, 32'h0200_0000, 5'd25, 1);
      add(0, 32'h0200_0000, 1, 32'h0,         5'd0,  0);
      // rotation with wrap: 0, 1, 31, 0
      add(1, 32'h8000_0003, 0, 32'h0,         5'd0,  0);
      add(0, 32'h8000_0003, 0, 32'h0000_0001, 5'd0,  1);
      add(0, 32'h8000_0003, 1, 32'h0,         5'd0,  0);
      add(0, 32'h8000_0003, 0, 32'h0000_0002, 5'd1,  1);
      add(0, 32'h8000_0003, 1, 32'h0,         5'd0,  0);
      add(0, 32'h8000_0003, 0, 32'h8000_0000, 5'd31, 1);
      add(0, 32'h8000_0003, 1, 32'h0,         5'd0,  0);
      add(0, 32'h8000_0003, 0, 32'h0000_0001, 5'd0,  1);
      add(0, 32'h8000_0003, 1, 32'h0,         5'd0,  0);
      // drop request: grant 4, drop, pointer now 5 so 5 beats 4
      add(0, 32'h0000_0010, 0, 32'h0000_0010, 5'd4,  1);
      add(0, 32'h0000_0000, 0, 32'h0,         5'd0,  0);
      add(0, 32'h0000_0030, 0, 32'h0000_0020, 5'd5,  1);
      add(0, 32'h0000_0000, 0, 32'h0,         5'd0,  0);
      // mid-grant reset, pointer back to 0
      add(0, 32'h0000_0200, 0, 32'h0000_0200, 5'd9,  1);
      add(1, 32'h0000_0201, 0, 32'h0,         5'd0,  0);
      add(0, 32'h0000_0201, 0, 32'h0000_0001, 5'd0,  1);
      add(0, 32'h0000_0201, 1, 32'h0,         5'd0,  0);
      // done in idle ignored
      add(0, 32'h0000_0000, 1, 32'h0,         5'd0,  0);
      add(0, 32'h0000_0000, 0, 32'h0,         5'd0,  0);
      // other requests during a grant have no effect
      add(0, 32'h0000_0100, 0, 32'h0000_0100, 5'd8,  1);
      add(0, 32'h0000_0101, 0, 32'h0000_0100, 5'd8,  1);
      add(0, 32'hFFFF_FFFF, 0, 32'h0000_0100, 5'd8,  1);
      add(0, 32'hFFFF_FFFF, 1, 32'h0,         5'd0,  0);

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rst, vecs[i].req, vecs[i].done);
         check($sformatf("vec%0d.gnt", i),       bus.gnt,               vecs[i].e_gnt);
         check($sformatf("vec%0d.gnt_idx", i),   32'(bus.gnt_idx),      32'(vecs[i].e_idx));
         check($sformatf("vec%0d.gnt_valid", i), 32'(bus.gnt_valid),    32'(vecs[i].e_vld));
         check($sformatf("vec%0d.timeout", i),   32'(bus.timeout),      32'd0);
      end

      // Long hold on requester 3 with requester 5 also waiting.
      cycle(1, 32'h0, 0);
      cycle(0, 32'h0000_0028, 0);
      check("hold.first_gnt", bus.gnt, 32'h0000_0008);
      for (int k = 1; k < (TO_EN ? TIMEOUT : 100); k++) begin
         cycle(0, 32'h0000_0028, 0);
         check($sformatf("hold%0d.gnt", k), bus.gnt, 32'h0000_0008);
         check($sformatf("hold%0d.timeout", k), 32'(bus.timeout), 32'd0);
      end
`ifdef ARB_TIMEOUT_EN
      cycle(0, 32'h0000_0028, 0);
      check("to.gnt", bus.gnt, 32'h0);
      check("to.pulse", 32'(bus.timeout), 32'd1);
      cycle(0, 32'h0000_0028, 0);
      check("to.next_gnt", bus.gnt, 32'h0000_0020);
      check("to.pulse_end", 32'(bus.timeout), 32'd0);
      // release on the expiry cycle: release wins, no timeout pulse
      for (int k = 1; k < TIMEOUT; k++) cycle(0, 32'h0000_0028, 0);
      check("coin.held", bus.gnt, 32'h0000_0020);
      cycle(0, 32'h0000_0028, 1);
      check("coin.gnt", bus.gnt, 32'h0);
      check("coin.timeout", 32'(bus.timeout), 32'd0);
`endif

      // Randomized run against the reference model.
      cycle(1, 32'h0, 0);
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] rq;
         bit rst, dn;
         case ($urandom_range(0, 3))
            0:       rq = 32'h0;
            1:       rq = 32'b1 << $urandom_range(0, 31);
            2:       rq = $urandom() & $urandom() & $urandom();
            default: rq = $urandom();
         endcase
         if ($urandom_range(0, 3) == 0 && m_owner >= 0) rq[m_owner] = 1'b0;
         else if (m_owner >= 0 && $urandom_range(0, 1) == 0) rq[m_owner] = 1'b1;
         dn  = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 199) == 0);
         cycle(rst, rq, dn);
         check_model($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
